// File: rtl/controller_mc.sv
// Multicycle instruction-sequencing controller: fetch, decode, jump, execute,
// multicycle ALU wait, register store, halt and a sticky error state.
module controller_mc #(
  parameter int OP_W    = 4,
  parameter int ALU_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             CLB,
  input  logic             z,
  input  logic             c,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  input  logic             alu_done,
  input  logic             resume,
  output logic             LoadIR,
  output logic             IncPC,
  output logic             SelPC,
  output logic             LoadPC,
  output logic             LoadReg,
  output logic             LoadAcc,
  output logic [1:0]       SelACC,
  output logic [ALU_W-1:0] SelALU,
  output logic             alu_start,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_INCPC   = 4'd2,
    S_JUMP    = 4'd3,
    S_EXEC    = 4'd4,
    S_ALUWAIT = 4'd5,
    S_STREG   = 4'd6,
    S_HALT    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZRS = 4'b0110;
  localparam logic [3:0] OP_JZIM = 4'b0111;
  localparam logic [3:0] OP_JCRS = 4'b1000;
  localparam logic [3:0] OP_JCIM = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_LDIM = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_hi_nz;

  // Opcode bits above [3:0] are reserved; any set bit makes the opcode illegal.
  assign op_hi_nz = (op >> 4) != '0;
  assign state_o  = state_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    LoadIR    = 1'b0;
    IncPC     = 1'b0;
    SelPC     = 1'b0;
    LoadPC    = 1'b0;
    LoadReg   = 1'b0;
    LoadAcc   = 1'b0;
    SelACC    = 2'b00;
    SelALU    = '0;
    alu_start = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        if (mem_ready) begin
          LoadIR  = 1'b1;
          state_d = S_INCPC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end
      end

      // Decode uses the live opcode and flags; later states only see op_q.
      S_INCPC: begin
        IncPC = 1'b1;
        op_d  = op[3:0];
        if (op_hi_nz) begin
          state_d = S_ERR;
        end else begin
          case (op[3:0])
            OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR,
            OP_MOVR, OP_LDIM:  state_d = S_EXEC;
            OP_MOVA:           state_d = S_STREG;
            OP_JZRS, OP_JZIM:  state_d = z ? S_JUMP : S_FETCH;
            OP_JCRS, OP_JCIM:  state_d = c ? S_JUMP : S_FETCH;
            OP_NOP:            state_d = S_FETCH;
            OP_HALT:           state_d = S_HALT;
            default:           state_d = S_ERR;
          endcase
        end
      end

      S_JUMP: begin
        LoadPC  = 1'b1;
        SelPC   = (op_q == OP_JZRS) || (op_q == OP_JCRS);
        state_d = S_FETCH;
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
            alu_start = 1'b1;
            SelALU    = ALU_W'(op_q);
            state_d   = S_ALUWAIT;
          end
          OP_MOVR: begin
            LoadAcc = 1'b1;
            SelACC  = 2'b10;
            state_d = S_FETCH;
          end
          OP_LDIM: begin
            LoadAcc = 1'b1;
            SelACC  = 2'b11;
            state_d = S_FETCH;
          end
          default: state_d = S_ERR;
        endcase
      end

      S_ALUWAIT: begin
        SelALU = ALU_W'(op_q);
        if (alu_done) begin
          LoadAcc = 1'b1;
          SelACC  = 2'b00;
          state_d = S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end
      end

      S_STREG: begin
        LoadReg = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) state_d = S_FETCH;
      end

      S_ERR: illegal = 1'b1;

      default: state_d = S_INIT;
    endcase

    // Wait counter restarts on any transition and saturates instead of wrapping.
    if (state_d != state_q)    cnt_d = '0;
    else if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    else                        cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      state_q <= S_INIT;
      op_q    <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_controller_mc.sv
// Directed bench for controller_mc: walks instruction sequences cycle by cycle
// and checks state and all outputs against hand-computed values.
module tb_controller_mc;

  localparam int OP_W    = 4;
  localparam int ALU_W   = 4;
  localparam int TIMEOUT = 4;

  localparam logic [3:0] INIT = 4'd0, FETCH = 4'd1, INCPC = 4'd2, JUMP = 4'd3,
                         EXEC = 4'd4, ALUWAIT = 4'd5, STREG = 4'd6, HALT = 4'd7,
                         ERR = 4'd8;

  // Output vector bits: {LoadIR,IncPC,SelPC,LoadPC,LoadReg,LoadAcc,alu_start,halted,illegal}
  localparam logic [8:0] O_NONE = 9'b0_0000_0000;
  localparam logic [8:0] O_IR   = 9'b1_0000_0000;
  localparam logic [8:0] O_INC  = 9'b0_1000_0000;
  localparam logic [8:0] O_SPC  = 9'b0_0100_0000;
  localparam logic [8:0] O_LPC  = 9'b0_0010_0000;
  localparam logic [8:0] O_LREG = 9'b0_0001_0000;
  localparam logic [8:0] O_LACC = 9'b0_0000_1000;
  localparam logic [8:0] O_ST   = 9'b0_0000_0100;
  localparam logic [8:0] O_HALT = 9'b0_0000_0010;
  localparam logic [8:0] O_ILL  = 9'b0_0000_0001;

  logic clk = 1'b0;
  logic CLB, z, c, mem_ready, alu_done, resume;
  logic [OP_W-1:0]  op;
  logic             LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]       SelACC;
  logic [ALU_W-1:0] SelALU;
  logic             alu_start, halted, illegal;
  logic [3:0]       state_o;
  logic [8:0]       ov;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controller_mc #(.OP_W(OP_W), .ALU_W(ALU_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .CLB(CLB), .z(z), .c(c), .op(op), .mem_ready(mem_ready),
    .alu_done(alu_done), .resume(resume), .LoadIR(LoadIR), .IncPC(IncPC),
    .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc),
    .SelACC(SelACC), .SelALU(SelALU), .alu_start(alu_start), .halted(halted),
    .illegal(illegal), .state_o(state_o)
  );

  assign ov = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, alu_start, halted, illegal};

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Lets freshly driven inputs settle, then compares {state, outputs, SelACC, SelALU}.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [8:0] o,
                     input logic [1:0] sa, input logic [3:0] alu);
    logic [18:0] obs, exp;
    #1;
    obs = {state_o, ov, SelACC, SelALU};
    exp = {st, o, sa, alu};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed state=%0d out=%b selacc=%b selalu=%h expected state=%0d out=%b selacc=%b selalu=%h",
             tag, obs[18:15], obs[14:6], obs[5:4], obs[3:0], exp[18:15], exp[14:6], exp[5:4], exp[3:0]);
    end
  endtask

  initial begin
    CLB = 1'b1; z = 1'b0; c = 1'b0; mem_ready = 1'b1; alu_done = 1'b0;
    resume = 1'b0; op = 4'b0001;
    cyc("reset", INIT, O_NONE, 2'b00, 4'h0);
    next();
    CLB = 1'b0;
    cyc("init_after_release", INIT, O_NONE, 2'b00, 4'h0);

    // ADD with alu_done on the third ALUWAIT cycle
    next(); cyc("add_fetch", FETCH, O_IR, 2'b00, 4'h0);
    next(); cyc("add_incpc", INCPC, O_INC, 2'b00, 4'h0);
    next(); cyc("add_exec", EXEC, O_ST, 2'b00, 4'h1);
    next(); cyc("add_wait1", ALUWAIT, O_NONE, 2'b00, 4'h1);
    next(); cyc("add_wait2", ALUWAIT, O_NONE, 2'b00, 4'h1);
    next(); alu_done = 1'b1;
    cyc("add_wait3_done", ALUWAIT, O_LACC, 2'b00, 4'h1);
    next(); alu_done = 1'b0; op = 4'b0110; z = 1'b1;
    cyc("add_back_fetch", FETCH, O_IR, 2'b00, 4'h0);

    // JZRS taken, then JZIM not taken
    next(); cyc("jzrs_incpc", INCPC, O_INC, 2'b00, 4'h0);
    next(); z = 1'b0;
    cyc("jzrs_jump", JUMP, O_LPC | O_SPC, 2'b00, 4'h0);
    next(); op = 4'b0111;
    cyc("jzim_fetch", FETCH, O_IR, 2'b00, 4'h0);
    next(); cyc("jzim_incpc", INCPC, O_INC, 2'b00, 4'h0);
    next(); op = 4'b1000; c = 1'b1;
    cyc("jzim_not_taken", FETCH, O_IR, 2'b00, 4'h0);

    // JCRS taken
    next(); cyc("jcrs_incpc", INCPC, O_INC, 2'b00, 4'h0);
    next(); c = 1'b0; op = 4'b1101;
    cyc("jcrs_jump", JUMP, O_LPC | O_SPC, 2'b00, 4'h0);

    // LDIM then MOVA, with op disturbed after decode
    next(); cyc("ldim_fetch", FETCH, O_IR, 2'b00, 4'h0);
    next(); cyc("ldim_incpc", INCPC, O_INC, 2'b00, 4'h0);
    next(); op = 4'b0001;
    cyc("ldim_exec", EXEC, O_LACC, 2'b11, 4'h0);
    next(); op = 4'b0101;
    cyc("mova_fetch", FETCH, O_IR, 2'b00, 4'h0);
    next(); cyc("mova_incpc", INCPC, O_INC, 2'b00, 4'h0);
    next(); op = 4'b0001;
    cyc("mova_streg", STREG, O_LREG, 2'b00, 4'h0);
    next(); op = 4'b1111;
    cyc("halt_fetch", FETCH, O_IR, 2'b00, 4'h0);

    // HALT held five cycles, resume on the sixth
    next(); cyc("halt_incpc", INCPC, O_INC, 2'b00, 4'h0);
    for (int i = 0; i < 5; i++) begin
      next(); cyc($sformatf("halt_hold%0d", i), HALT, O_HALT, 2'b00, 4'h0);
    end
    next(); resume = 1'b1;
    cyc("halt_resume_cycle", HALT, O_HALT, 2'b00, 4'h0);
    next(); resume = 1'b0; op = 4'b1001;
    cyc("halt_exit_fetch", FETCH, O_IR, 2'b00, 4'h0);

    // Undefined opcode 1001 goes straight to ERR and stays
    next(); cyc("illop_incpc", INCPC, O_INC, 2'b00, 4'h0);
    next(); resume = 1'b1;
    cyc("illop_err", ERR, O_ILL, 2'b00, 4'h0);
    next(); next(); resume = 1'b0;
    cyc("illop_err_sticky", ERR, O_ILL, 2'b00, 4'h0);

    // Asynchronous reset out of ERR, then fetch timeout
    CLB = 1'b1;
    cyc("clb_from_err", INIT, O_NONE, 2'b00, 4'h0);
    next(); CLB = 1'b0; mem_ready = 1'b0;
    next(); cyc("to_fetch1", FETCH, O_NONE, 2'b00, 4'h0);
    next(); cyc("to_fetch2", FETCH, O_NONE, 2'b00, 4'h0);
    next(); cyc("to_fetch3", FETCH, O_NONE, 2'b00, 4'h0);
    next(); cyc("to_fetch4", FETCH, O_NONE, 2'b00, 4'h0);
    next(); mem_ready = 1'b1;
    cyc("to_err", ERR, O_ILL, 2'b00, 4'h0);
    next(); cyc("to_err_sticky", ERR, O_ILL, 2'b00, 4'h0);

    // SUB with no alu_done: ALUWAIT times out after four cycles
    CLB = 1'b1; op = 4'b0010;
    next(); CLB = 1'b0;
    next(); next();
    next(); cyc("sub_exec", EXEC, O_ST, 2'b00, 4'h2);
    for (int i = 0; i < 4; i++) begin
      next(); cyc($sformatf("sub_wait%0d", i), ALUWAIT, O_NONE, 2'b00, 4'h2);
    end
    next(); alu_done = 1'b1;
    cyc("alu_to_err", ERR, O_ILL, 2'b00, 4'h0);
    alu_done = 1'b0;

    // Reset pulse in the middle of an ALUWAIT cycle with alu_done high
    CLB = 1'b1; op = 4'b0011;
    next(); CLB = 1'b0;
    next(); next();
    next(); cyc("nor_exec", EXEC, O_ST, 2'b00, 4'h3);
    next(); alu_done = 1'b1;
    cyc("nor_wait_done", ALUWAIT, O_LACC, 2'b00, 4'h3);
    CLB = 1'b1;
    cyc("clb_mid_aluwait", INIT, O_NONE, 2'b00, 4'h0);
    alu_done = 1'b0;
    next(); CLB = 1'b0;
    next(); cyc("fetch_after_clb", FETCH, O_IR, 2'b00, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
